// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port integer register file.
// Two write ports (port 1 wins on an address conflict), NUM_RD combinational
// read ports, optional hardwired-zero entry 0, and a one-entry-per-cycle
// sweep-clear engine started by clr_req.
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write data
// to matching read ports. Without it, a read returns the stored (pre-write) value.
module regfile_mp #(
    parameter int XLEN    = 32,
    parameter int DEPTH   = 32,
    parameter int AW      = $clog2(DEPTH),
    parameter int NUM_RD  = 2,
    parameter int ZERO_R0 = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr_req,
    output logic                   busy,
    input  logic                   we0,
    input  logic [AW-1:0]          waddr0,
    input  logic [XLEN-1:0]        wdata0,
    input  logic                   we1,
    input  logic [AW-1:0]          waddr1,
    input  logic [XLEN-1:0]        wdata1,
    input  logic [NUM_RD*AW-1:0]   raddr,
    output logic [NUM_RD*XLEN-1:0] rdata
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [AW-1:0] clr_ptr_q, clr_ptr_d;
    logic          clearing;

    // All entries packed side by side; entry i lives at [i*XLEN +: XLEN].
    logic [DEPTH*XLEN-1:0] rf_flat;

    assign clearing = (state_q == ST_CLEAR);
    assign busy     = clearing;

    // Sweep FSM: one entry per cycle, returns to IDLE after clearing the last one.
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        if (state_q == ST_IDLE) begin
            if (clr_req) begin
                state_d   = ST_CLEAR;
                clr_ptr_d = '0;
            end
        end else begin
            clr_ptr_d = clr_ptr_q + 1'b1;
            if (clr_ptr_q == AW'(DEPTH - 1)) begin
                state_d = ST_IDLE;
            end
        end
    end

    // FSM state and sweep pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    // Storage: one register per entry. Entry 0 has no storage when hardwired to zero,
    // which also discards any write to it on both ports.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            if ((ZERO_R0 != 0) && (gi == 0)) begin : g_zero
                assign rf_flat[gi*XLEN +: XLEN] = '0;
            end else begin : g_store
                logic [XLEN-1:0] entry_q, entry_d;

                // Next value: sweep clear takes over; otherwise port 1 overrides port 0.
                always_comb begin
                    entry_d = entry_q;
                    if (clearing) begin
                        if (clr_ptr_q == AW'(gi)) begin
                            entry_d = '0;
                        end
                    end else begin
                        if (we0 && (waddr0 == AW'(gi))) begin
                            entry_d = wdata0;
                        end
                        if (we1 && (waddr1 == AW'(gi))) begin
                            entry_d = wdata1;
                        end
                    end
                end

                // Entry register, cleared by reset.
                always_ff @(posedge clk) begin
                    if (rst) begin
                        entry_q <= '0;
                    end else begin
                        entry_q <= entry_d;
                    end
                end

                assign rf_flat[gi*XLEN +: XLEN] = entry_q;
            end
        end
    endgenerate

    // Read ports: combinational, zero latency.
    genvar gk;
    generate
        for (gk = 0; gk < NUM_RD; gk++) begin : g_rd
            logic [AW-1:0]   addr;
            logic [XLEN-1:0] rd_val;

            assign addr = raddr[gk*AW +: AW];

            // Select stored word, optionally forward same-cycle writes, force zero for entry 0.
            always_comb begin
                rd_val = rf_flat[addr*XLEN +: XLEN];
`ifdef REGFILE_BYPASS_EN
                if (!clearing && !rst) begin
                    if (we0 && (waddr0 == addr)) begin
                        rd_val = wdata0;
                    end
                    if (we1 && (waddr1 == addr)) begin
                        rd_val = wdata1;
                    end
                end
`endif
                if ((ZERO_R0 != 0) && (addr == '0)) begin
                    rd_val = '0;
                end
            end

            assign rdata[gk*XLEN +: XLEN] = rd_val;
        end
    endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp with default parameters (32x32, 2 read ports,
// entry 0 hardwired zero). Reference model: a plain array plus a count of
// sweep cycles remaining.
module tb_regfile_mp;

    localparam int XLEN = 32;
    localparam int DEPTH = 32;
    localparam int AW = 5;
    localparam int NUM_RD = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   clr_req;
    logic                   busy;
    logic                   we0, we1;
    logic [AW-1:0]          waddr0, waddr1;
    logic [XLEN-1:0]        wdata0, wdata1;
    logic [NUM_RD*AW-1:0]   raddr;
    logic [NUM_RD*XLEN-1:0] rdata;

    int checks_cnt = 0;
    int passed_cnt = 0;

    // Reference model
    logic [XLEN-1:0] ref_rf [DEPTH];
    int              sweep_left;

    always #5 clk = ~clk;

    regfile_mp #(
        .XLEN(XLEN), .DEPTH(DEPTH), .AW(AW), .NUM_RD(NUM_RD), .ZERO_R0(1)
    ) dut (
        .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr(raddr), .rdata(rdata)
    );

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        checks_cnt++;
        assert (obs === exp) passed_cnt++;
        else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected read value for an address given current model state and inputs.
    function automatic logic [XLEN-1:0] exp_read(input logic [AW-1:0] a);
        logic [XLEN-1:0] v;
        if (a == 0) return '0;
        v = ref_rf[a];
`ifdef REGFILE_BYPASS_EN
        if (sweep_left == 0) begin
            if (we0 && waddr0 == a) v = wdata0;
            if (we1 && waddr1 == a) v = wdata1;
        end
`endif
        return v;
    endfunction

    // Model of one rising edge.
    task automatic model_edge();
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) ref_rf[i] = '0;
            sweep_left = 0;
        end else if (sweep_left > 0) begin
            ref_rf[DEPTH - sweep_left] = '0;
            sweep_left--;
        end else begin
            if (we0 && waddr0 != 0) ref_rf[waddr0] = wdata0;
            if (we1 && waddr1 != 0) ref_rf[waddr1] = wdata1;
            if (clr_req) sweep_left = DEPTH;
        end
    endtask

    // Check outputs mid-cycle, clock once, update model. Inputs may change afterwards.
    task automatic tick();
        #1;
        chk("busy", {31'b0, busy}, {31'b0, (sweep_left > 0)});
        if (!rst) begin
            chk($sformatf("rd0[%0d]", raddr[0 +: AW]), rdata[0 +: XLEN], exp_read(raddr[0 +: AW]));
            chk($sformatf("rd1[%0d]", raddr[AW +: AW]), rdata[XLEN +: XLEN], exp_read(raddr[AW +: AW]));
        end
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        we0 = 0; we1 = 0; clr_req = 0; rst = 0;
        waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0;
    endtask

    task automatic rand_inputs(input bit allow_ctrl);
        we0    = 1'($urandom_range(0, 1));
        we1    = 1'($urandom_range(0, 1));
        waddr0 = AW'($urandom);
        waddr1 = ($urandom_range(0, 3) == 0) ? waddr0 : AW'($urandom);
        wdata0 = $urandom;
        wdata1 = $urandom;
        raddr  = {AW'($urandom), AW'($urandom)};
        clr_req = allow_ctrl && ($urandom_range(0, 40) == 0);
        rst     = allow_ctrl && ($urandom_range(0, 80) == 0);
    endtask

    initial begin
        int n;
        logic [XLEN-1:0] tmp;
        idle_inputs();
        raddr = '0;
        sweep_left = 0;
        for (int i = 0; i < DEPTH; i++) ref_rf[i] = 'x;

        // 1. Reset, then every address reads 0 on both ports.
        rst = 1;
        @(posedge clk);
        model_edge();
        #1;
        rst = 0;
        for (int a = 0; a < DEPTH; a++) begin
            raddr = {AW'(a), AW'(DEPTH - 1 - a)};
            tick();
        end

        // 2. Simple write, visible next cycle.
        we0 = 1; waddr0 = 5; wdata0 = 32'hDEADBEEF; raddr = {AW'(0), AW'(5)};
        tick();
        idle_inputs();
        #1;
        chk("wr5_rd0", rdata[0 +: XLEN], 32'hDEADBEEF);
        chk("x0_rd1", rdata[XLEN +: XLEN], 32'h0);
        tick();

        // 3. Write conflict: port 1 wins.
        we0 = 1; waddr0 = 7; wdata0 = 32'h1111_1111;
        we1 = 1; waddr1 = 7; wdata1 = 32'h2222_2222;
        tick();
        idle_inputs();
        raddr = {AW'(7), AW'(7)};
        #1;
        chk("conflict7", rdata[0 +: XLEN], 32'h2222_2222);
        tick();

        // 4. Writes to entry 0 discarded.
        we0 = 1; waddr0 = 0; wdata0 = 32'hFFFF_FFFF;
        we1 = 1; waddr1 = 0; wdata1 = 32'hFFFF_FFFF;
        raddr = {AW'(0), AW'(0)};
        tick();
        idle_inputs();
        #1;
        chk("x0_after_wr", rdata[0 +: XLEN], 32'h0);
        tick();

        // 5. Fill with index values, then sweep-clear with writes attempted throughout.
        for (int a = 1; a < DEPTH; a++) begin
            we0 = 1; waddr0 = AW'(a); wdata0 = XLEN'(a);
            tick();
        end
        idle_inputs();
        clr_req = 1;
        tick();
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            rand_inputs(1'b0);
            clr_req = 1'($urandom_range(0, 1));
            raddr = {AW'(31), AW'((n > 0) ? $urandom_range(0, n - 1) : 0)};
            if (n == 16) begin
                #1;
                chk("mid_sweep_31", rdata[XLEN +: XLEN], 32'd31);
                chk("mid_sweep_cleared", rdata[0 +: XLEN], 32'd0);
            end
            tick();
            n++;
        end
        chk("sweep_len", XLEN'(n), 32'd32);
        idle_inputs();
        for (int a = 0; a < DEPTH; a += 2) begin
            raddr = {AW'(a + 1), AW'(a)};
            tick();
        end

        // 6. Same-cycle write and read of entry 9.
        we0 = 1; waddr0 = 9; wdata0 = 32'h1234_5678;
        tick();
        we0 = 1; waddr0 = 9; wdata0 = 32'hA5A5_A5A5; raddr = {AW'(9), AW'(9)};
        #1;
`ifdef REGFILE_BYPASS_EN
        tmp = 32'hA5A5_A5A5;
`else
        tmp = 32'h1234_5678;
`endif
        chk("same_cycle_rd9", rdata[0 +: XLEN], tmp);
        tick();
        idle_inputs();
        chk("rd9_next", rdata[0 +: XLEN], 32'hA5A5_A5A5);

        // Reset at sweep cycle 10 aborts the sweep.
        for (int a = 1; a < DEPTH; a++) begin
            we1 = 1; waddr1 = AW'(a); wdata1 = $urandom | 32'h1;
            tick();
        end
        idle_inputs();
        clr_req = 1;
        tick();
        clr_req = 0;
        for (int c = 0; c < 10; c++) tick();
        rst = 1;
        tick();
        rst = 0;
        #1;
        chk("busy_after_rst", {31'b0, busy}, 32'd0);
        for (int a = 0; a < DEPTH; a += 2) begin
            raddr = {AW'(a + 1), AW'(a)};
            tick();
        end

        // Randomised traffic with occasional sweeps and resets.
        for (int c = 0; c < 600; c++) begin
            rand_inputs(1'b1);
            tick();
        end

        $display("%0d/%0d checks passed", passed_cnt, checks_cnt);
        $finish;
    end

endmodule
